// File: rtl/param_cmd_parser.sv
// -----------------------------------------------------------------------------
// param_cmd_parser
// Parses 7-byte parameter-write frames from a byte stream:
//   0xA5, ADDR, D3, D2, D1, D0, CHK   (CHK = ADDR^D3^D2^D1^D0, data MSB first)
// A frame with a good checksum and ADDR[7:3]==0 produces a one-cycle wr_en
// with param_addr/param_data. A frame with a bad checksum, a bad address or an
// inter-byte stall longer than TIMEOUT_CYCLES produces a one-cycle err with
// err_code (1 checksum, 2 bad address, 3 timeout).
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   rx_data    : incoming byte
//   rx_valid   : rx_data valid
//   rx_ready   : parser can take a byte (low only during the write cycle)
//   param_addr : slot index of the last write (held)
//   param_data : value of the last write (held)
//   wr_en      : one-cycle write strobe
//   err        : one-cycle error strobe
//   err_code   : cause of the most recent error (held)
//   ok_count   : frames written (wraps)
//   err_count  : errored frames (wraps)
// -----------------------------------------------------------------------------
module param_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [2:0]  param_addr,
  output logic [31:0] param_data,
  output logic        wr_en,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] ok_count,
  output logic [15:0] err_count
);

  // The idle counter only ever needs to hold 0..TIMEOUT_CYCLES-1: the
  // expiring cycle is detected from the last value rather than stored.
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CHK   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  logic [2:0]    r_state;
  logic [TW-1:0] r_tmo;
  logic [1:0]    r_cnt;
  logic [7:0]    r_addr;
  logic [31:0]   r_shift;
  logic [7:0]    r_chk;
  logic          r_wr;
  logic          r_err;
  logic [1:0]    r_code;
  logic [2:0]    r_paddr;
  logic [31:0]   r_pdata;
  logic [15:0]   r_ok;
  logic [15:0]   r_errc;

  logic w_ready;
  logic w_accept;
  logic w_in_frame;
  logic w_expire;

  assign w_ready    = (r_state != S_WRITE);
  assign w_accept   = rx_valid && w_ready;
  assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_CHK);
  // An accepted byte in the expiring cycle wins over the timeout.
  assign w_expire   = w_in_frame && !w_accept && (r_tmo == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tmo   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_shift <= '0;
      r_chk   <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= '0;
      r_paddr <= '0;
      r_pdata <= '0;
      r_ok    <= '0;
      r_errc  <= '0;
    end else begin
      r_wr  <= 1'b0;
      r_err <= 1'b0;

      if (w_accept || !w_in_frame || w_expire) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept && (rx_data == SYNC_BYTE)) begin
            r_state <= S_ADDR;
            r_cnt   <= '0;
          end
        end
        S_ADDR: begin
          if (w_accept) begin
            r_addr  <= rx_data;
            r_chk   <= rx_data;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_shift <= {r_shift[23:0], rx_data};
            r_chk   <= r_chk ^ rx_data;
            r_cnt   <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (w_accept) begin
            // Checksum failure is reported ahead of a bad address.
            if (rx_data != r_chk) begin
              r_err   <= 1'b1;
              r_code  <= 2'd1;
              r_errc  <= r_errc + 16'd1;
              r_state <= S_IDLE;
            end else if (r_addr[7:3] != 5'd0) begin
              r_err   <= 1'b1;
              r_code  <= 2'd2;
              r_errc  <= r_errc + 16'd1;
              r_state <= S_IDLE;
            end else begin
              r_wr    <= 1'b1;
              r_paddr <= r_addr[2:0];
              r_pdata <= r_shift;
              r_ok    <= r_ok + 16'd1;
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Expiry only fires with no byte accepted, so it never collides with
      // the accept branches above.
      if (w_expire) begin
        r_err   <= 1'b1;
        r_code  <= 2'd3;
        r_errc  <= r_errc + 16'd1;
        r_state <= S_IDLE;
      end
    end
  end

  assign rx_ready   = w_ready;
  assign param_addr = r_paddr;
  assign param_data = r_pdata;
  assign wr_en      = r_wr;
  assign err        = r_err;
  assign err_code   = r_code;
  assign ok_count   = r_ok;
  assign err_count  = r_errc;

endmodule
